// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the next-PC controller: FSM states, PC source
// selects, the exception vector and the redirect record with its priority merge.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10,
        ST_EXC   = 2'b11
    } state_t;

    // Encodings are ordered by redirect priority, so a larger value wins.
    typedef enum logic [1:0] {
        SEL_PC4 = 2'b00,
        SEL_BR  = 2'b01,
        SEL_JMP = 2'b10,
        SEL_EPC = 2'b11
    } pc_sel_t;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    typedef struct packed {
        logic    valid;
        pc_sel_t sel;
    } redir_t;

    localparam redir_t REDIR_NONE = '{valid: 1'b0, sel: SEL_PC4};

    // Keeps the higher-priority redirect; on a tie the second operand wins.
    function automatic redir_t redir_max(input redir_t a, input redir_t b);
        if (!a.valid) return b;
        if (!b.valid) return a;
        return (b.sel >= a.sel) ? b : a;
    endfunction

endpackage

// File: rtl/redir_prio.sv
// Merges the pending redirect with the live ID-stage redirect inputs into a
// single {valid, sel}; live inputs only count when live_en is set.
module redir_prio
    import pc_ctrl_pkg::*;
(
    input  redir_t pend,
    input  logic   live_en,
    input  logic   eret,
    input  logic   jump,
    input  logic   branch_taken,
    output redir_t merged
);

    redir_t live;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        live = REDIR_NONE;
        if (live_en) begin
            if (eret) begin
                live = '{valid: 1'b1, sel: SEL_EPC};
            end else if (jump) begin
                live = '{valid: 1'b1, sel: SEL_JMP};
            end else if (branch_taken) begin
                live = '{valid: 1'b1, sel: SEL_BR};
            end
        end
    end

    assign merged = redir_max(pend, live);

endmodule

// File: rtl/next_pc_ctrl.sv
// Next-PC controller: sequences instruction fetch, holds the PC under stall,
// remembers the strongest pending redirect and takes exceptions.
module next_pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       if_ack,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic       jump,
    input  logic       eret,
    input  logic       except_req,
    output logic       if_req,
    output logic       pc_write,
    output logic [1:0] pc_sel,
    output logic       pc_except,
    output logic       flush_if,
    output logic       busy_hold
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] boot_cnt_q, boot_cnt_d;
    redir_t     pend_q, pend_d;
    redir_t     merged;
    logic       live_en;

    assign live_en = (state_q == ST_FETCH) || (state_q == ST_HOLD);

    redir_prio u_redir_prio (
        .pend         (pend_q),
        .live_en      (live_en),
        .eret         (eret),
        .jump         (jump),
        .branch_taken (branch_taken),
        .merged       (merged)
    );

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
            pend_q     <= REDIR_NONE;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pend_d     = pend_q;
        if_req     = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = SEL_PC4;
        pc_except  = 1'b0;
        flush_if   = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    boot_cnt_d = '0;
                    state_d    = ST_FETCH;
                end else begin
                    boot_cnt_d = boot_cnt_q + 4'd1;
                end
            end

            ST_FETCH, ST_HOLD: begin
                if_req = (state_q == ST_FETCH);
                if (except_req) begin
                    // The exception wins over any write and drops the redirect.
                    pend_d  = REDIR_NONE;
                    state_d = ST_EXC;
                end else if (!stall && (if_ack || state_q == ST_HOLD)) begin
                    pc_write = 1'b1;
                    pc_sel   = merged.valid ? merged.sel : SEL_PC4;
                    flush_if = merged.valid && (merged.sel == SEL_EPC);
                    pend_d   = REDIR_NONE;
                    state_d  = ST_FETCH;
                end else begin
                    pend_d = merged;
                    if (if_ack) state_d = ST_HOLD;
                end
            end

            ST_EXC: begin
                pc_write  = 1'b1;
                pc_except = 1'b1;
                flush_if  = 1'b1;
                state_d   = ST_FETCH;
            end

            default: state_d = ST_BOOT;
        endcase
    end

    // The entry being consumed by this cycle's write no longer counts as pending.
    assign busy_hold = pend_q.valid && !pc_write;

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Scoreboard bench for next_pc_ctrl: the stimulus pushes the hand-computed
// output vector for each cycle, a monitor pops and compares it mid-cycle.
module tb_next_pc_ctrl;

    typedef struct packed {
        logic       if_req;
        logic       pc_write;
        logic [1:0] pc_sel;
        logic       pc_except;
        logic       flush_if;
        logic       busy_hold;
    } out_t;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       if_ack = 1'b0, stall = 1'b0, branch_taken = 1'b0;
    logic       jump = 1'b0, eret = 1'b0, except_req = 1'b0;
    logic       if_req, pc_write, pc_except, flush_if, busy_hold;
    logic [1:0] pc_sel;

    out_t  act;
    out_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passed = 0;

    next_pc_ctrl #(.BOOT_CYCLES(2)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .if_ack       (if_ack),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jump         (jump),
        .eret         (eret),
        .except_req   (except_req),
        .if_req       (if_req),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .pc_except    (pc_except),
        .flush_if     (flush_if),
        .busy_hold    (busy_hold)
    );

    always #5 CLK = ~CLK;

    assign act = {if_req, pc_write, pc_sel, pc_except, flush_if, busy_hold};

    function automatic out_t ex(input logic ir, input logic w, input logic [1:0] s,
                                input logic x, input logic f, input logic b);
        return {ir, w, s, x, f, b};
    endfunction

    // Drive one cycle's inputs just after the edge and queue what that cycle must show.
    task automatic step(input logic rst, input logic ack, input logic stl, input logic br,
                        input logic jmp, input logic er, input logic exc,
                        input out_t e, input string nm);
        @(posedge CLK);
        #1;
        reset        = rst;
        if_ack       = ack;
        stall        = stl;
        branch_taken = br;
        jump         = jmp;
        eret         = er;
        except_req   = exc;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge CLK) begin
        out_t  e;
        string nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (act === e) passed++;
            else $display("FAIL %s: got {if_req,pc_write,pc_sel,pc_except,flush_if,busy_hold}=%b want %b",
                          nm, act, e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //    rst ack stl br jmp er exc  expected {if_req,wr,sel,exc,flush,busy}
        step(0, 0, 0, 0, 0, 0, 0, ex(0, 0, 2'b00, 0, 0, 0), "reset_state");
        step(1, 0, 0, 0, 0, 0, 0, ex(0, 0, 2'b00, 0, 0, 0), "boot_cycle1");
        step(1, 1, 0, 1, 0, 0, 1, ex(0, 0, 2'b00, 0, 0, 0), "boot_cycle2_ignores_inputs");
        step(1, 0, 0, 0, 0, 0, 0, ex(1, 0, 2'b00, 0, 0, 0), "fetch_wait_no_pending");
        step(1, 1, 0, 0, 0, 0, 0, ex(1, 1, 2'b00, 0, 0, 0), "first_write_pc4");
        // Branch arrives with a stalled ack, then released three cycles later.
        step(1, 1, 1, 1, 0, 0, 0, ex(1, 0, 2'b00, 0, 0, 0), "hold_entry_branch");
        step(1, 0, 1, 0, 0, 0, 0, ex(0, 0, 2'b00, 0, 0, 1), "hold_busy1");
        step(1, 0, 1, 0, 0, 0, 0, ex(0, 0, 2'b00, 0, 0, 1), "hold_busy2");
        step(1, 0, 1, 0, 0, 0, 0, ex(0, 0, 2'b00, 0, 0, 1), "hold_busy3");
        step(1, 0, 0, 0, 0, 0, 0, ex(0, 1, 2'b01, 0, 0, 0), "hold_release_branch");
        // Branch, then jump, then eret, then a weaker branch during one stall.
        step(1, 1, 1, 1, 0, 0, 0, ex(1, 0, 2'b00, 0, 0, 0), "hold_entry_branch2");
        step(1, 0, 1, 0, 1, 0, 0, ex(0, 0, 2'b00, 0, 0, 1), "hold_jump_upgrade");
        step(1, 0, 1, 0, 0, 1, 0, ex(0, 0, 2'b00, 0, 0, 1), "hold_eret_upgrade");
        step(1, 0, 1, 1, 0, 0, 0, ex(0, 0, 2'b00, 0, 0, 1), "hold_branch_no_downgrade");
        step(1, 0, 0, 0, 0, 0, 0, ex(0, 1, 2'b11, 0, 1, 0), "release_eret_flush");
        step(1, 1, 0, 0, 1, 0, 0, ex(1, 1, 2'b10, 0, 0, 0), "live_jump_write_no_flush");
        step(1, 0, 0, 1, 0, 0, 0, ex(1, 0, 2'b00, 0, 0, 0), "fetch_wait_captures_branch");
        step(1, 0, 0, 0, 0, 0, 0, ex(1, 0, 2'b00, 0, 0, 1), "fetch_wait_pending");
        step(1, 1, 0, 0, 1, 0, 0, ex(1, 1, 2'b10, 0, 0, 0), "live_jump_beats_pending_branch");
        // Exception overrides a write that would otherwise happen.
        step(1, 1, 0, 0, 1, 0, 1, ex(1, 0, 2'b00, 0, 0, 0), "exc_overrides_write");
        step(1, 0, 0, 1, 0, 0, 1, ex(0, 1, 2'b00, 1, 1, 0), "exc_cycle");
        step(1, 0, 0, 0, 0, 0, 0, ex(1, 0, 2'b00, 0, 0, 0), "after_exc_fetch_empty");
        // Exception taken from HOLD discards the pending jump.
        step(1, 1, 1, 0, 1, 0, 0, ex(1, 0, 2'b00, 0, 0, 0), "hold_entry_jump");
        step(1, 0, 1, 0, 0, 0, 1, ex(0, 0, 2'b00, 0, 0, 1), "exc_from_hold");
        step(1, 0, 1, 0, 0, 0, 0, ex(0, 1, 2'b00, 1, 1, 0), "exc_cycle_from_hold");
        step(1, 1, 0, 0, 0, 0, 0, ex(1, 1, 2'b00, 0, 0, 0), "write_after_exc_pc4");
        // Reset pulsed in HOLD with a pending jump.
        step(1, 1, 1, 0, 1, 0, 0, ex(1, 0, 2'b00, 0, 0, 0), "hold_entry_jump2");
        step(1, 0, 1, 0, 0, 0, 0, ex(0, 0, 2'b00, 0, 0, 1), "hold_pending_jump");
        step(0, 0, 0, 0, 0, 0, 0, ex(0, 0, 2'b00, 0, 0, 0), "reset_in_hold_immediate");
        step(1, 1, 0, 0, 0, 0, 0, ex(0, 0, 2'b00, 0, 0, 0), "reboot_cycle1");
        step(1, 1, 0, 0, 0, 0, 0, ex(0, 0, 2'b00, 0, 0, 0), "reboot_cycle2");
        step(1, 1, 0, 0, 0, 0, 0, ex(1, 1, 2'b00, 0, 0, 0), "post_reset_write_pc4");

        repeat (3) @(posedge CLK);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
